image_stream_reader: RTL and testbench
======================================

Name: image_stream_reader

Overview:
- Source end of the pixel stream consumed by the Sobel top.
- On a start request, reads a WIDTH x HEIGHT 8-bit grayscale frame from a synchronous frame memory in raster order.
- Delivers each pixel as a data byte plus a one-cycle enable strobe, and holds the core run request for the whole frame.
- Waits for the core's done indication, then reports frame completion to the system controller.

Parameters:
- IMG_W, 256, pixels per row (>=3)
- IMG_H, 256, rows per frame (>=3)
- ADDR_W, 16, frame-memory address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
- RD_LAT, 1, frame-memory read latency in cycles (1..4)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- START_I  in  1  frame start request, level-sampled
- STALL_I  in  1  when high, no new memory read is issued
- CORE_DONE_I  in  1  done indication from the Sobel core
- MEM_RD_EN_O  out  1  frame-memory read strobe
- MEM_ADDR_O  out  ADDR_W  frame-memory read address
- MEM_DATA_I  in  8  frame-memory read data, valid RD_LAT cycles after MEM_RD_EN_O
- DATA_O  out  8  pixel byte to the core
- DATA_EN_O  out  1  pixel valid strobe, one cycle per pixel
- CORE_RUN_O  out  1  run request to the core
- BUSY_O  out  1  frame in progress
- DONE_O  out  1  one-cycle frame-complete pulse

Behaviour:
- Clock and reset: single clock CLK; RST_N is asynchronous, active-low.
- Reset values: all outputs 0, MEM_ADDR_O=0, state IDLE, counters 0, read-valid pipeline cleared.
- Reset mid-frame: aborts immediately; in-flight reads are discarded, with no DATA_EN_O and no DONE_O afterwards.
- FSM states:
  - IDLE: START_I=1 -> ISSUE. CORE_RUN_O and BUSY_O rise on the next cycle; the address counter and col/row counters are cleared.
  - ISSUE: each cycle with STALL_I=0, asserts MEM_RD_EN_O with MEM_ADDR_O=current address, then increments address and col. When col wraps from IMG_W-1 to 0, row increments. The cycle issuing the last address (row IMG_H-1, col IMG_W-1) moves to DRAIN. With STALL_I=1, MEM_RD_EN_O=0 and the counters hold.
  - DRAIN: no reads issued; waits until the read-valid pipeline is empty, then -> WAIT_CORE.
  - WAIT_CORE: CORE_RUN_O stays 1; on CORE_DONE_I=1 -> DONE.
  - DONE: DONE_O=1 for exactly one cycle; CORE_RUN_O and BUSY_O drop; -> IDLE.
- Address generation: a linear incrementing counter, no multiplier.
- Read-valid pipeline: MEM_RD_EN_O is shifted through an RD_LAT-deep valid shift register. When the tap is set, DATA_O is registered from MEM_DATA_I and DATA_EN_O=1 on the following cycle.
- Latency: first DATA_EN_O appears RD_LAT+1 cycles after the first MEM_RD_EN_O.
- Throughput: one pixel per cycle when unstalled.
- DATA_O holds its last value when DATA_EN_O=0.
- Stall: STALL_I gates issue only. Reads already in flight still emerge on DATA_EN_O during a stall; the consumer tolerates this.
- Pixel count: exactly IMG_W*IMG_H DATA_EN_O strobes per frame regardless of stall pattern.
- START_I while BUSY_O=1 is ignored. START_I held high through DONE starts a new frame from IDLE on the next cycle.
- CORE_DONE_I before WAIT_CORE is ignored (not latched).
- Simultaneous STALL_I=1 on the last issue cycle: the last read is not issued and the FSM stays in ISSUE until it is.

Decomposition:
- Shared package `sober_pkg`:
  - FSM state encoding (IDLE, ISSUE, DRAIN, WAIT_CORE, DONE)
  - default IMG_W/IMG_H constants
  - pixel width constant PIX_W=8, also used by the Sobel top
- One natural sub-module, `raster_addr_gen`, holds the col/row/linear-address counters. Inputs: clear, advance. Outputs: address, last-pixel flag.
- The read-valid pipeline and FSM stay in the parent.

Test Plan:
- Nominal frame: IMG_W=4, IMG_H=3, RD_LAT=1, memory[i]=i+0x10, START_I pulse.
  - Required: MEM_ADDR_O steps 0..11 on 12 consecutive cycles.
  - Required: DATA_O=0x10..0x1B with DATA_EN_O, first strobe 2 cycles after first read.
  - Required: CORE_RUN_O=1 throughout; CORE_DONE_I pulse yields DONE_O for 1 cycle and then IDLE.
- Stall: STALL_I=1 for cycles 3-5 of ISSUE.
  - Required: MEM_RD_EN_O=0 and address held for those 3 cycles.
  - Required: the in-flight pixel is still delivered; 12 strobes total, order unchanged, DONE after CORE_DONE_I.
- Latency sweep: RD_LAT=3.
  - Required: first DATA_EN_O 4 cycles after first MEM_RD_EN_O.
  - Required: DRAIN lasts until the last strobe; still 12 strobes.
- Start while busy and early core done:
  - START_I re-asserted mid-frame -> ignored; address sequence unaffected.
  - CORE_DONE_I pulsed during ISSUE -> ignored; DONE_O only after a CORE_DONE_I in WAIT_CORE.
- Reset mid-frame: RST_N low at address 6.
  - Required: all outputs 0 immediately; no DATA_EN_O from in-flight reads.
  - Required: a new START_I produces a full frame from address 0.
- Back-to-back: START_I held high.
  - Required: the second frame begins the cycle after the IDLE return.
  - Required: each frame produces exactly one DONE_O.

Source files
------------

// File: rtl/sober_pkg.sv
// Shared definitions for the Sobel pixel path: reader FSM encoding, pixel width
// and default frame geometry.
package sober_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        DRAIN     = 3'd2,
        WAIT_CORE = 3'd3,
        DONE      = 3'd4
    } rd_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order col/row/linear address counters; one step per advance, clear wins.
// Address is a plain incrementing counter so no multiplier sits on the read path.
module raster_addr_gen
    import sober_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_wrap;

    assign col_wrap = (col == COL_MAX);
    assign last     = col_wrap && (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (clear) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (advance) begin
            // Wrap everything after the final pixel so the address never leaves the frame.
            addr <= last ? '0 : addr + 1'b1;
            if (col_wrap) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_stream_reader.sv
// Reads one frame from a synchronous memory in raster order and streams it to the Sobel core;
// first pixel RD_LAT+1 cycles after the first read, STALL_I gates issue only (in-flight reads still emerge).
module image_stream_reader
    import sober_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START_I,
    input  logic              STALL_I,
    input  logic              CORE_DONE_I,
    output logic              MEM_RD_EN_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    input  logic [PIX_W-1:0]  MEM_DATA_I,
    output logic [PIX_W-1:0]  DATA_O,
    output logic              DATA_EN_O,
    output logic              CORE_RUN_O,
    output logic              BUSY_O,
    output logic              DONE_O
);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [RD_LAT-1:0] vld_sr;
    logic              rd_en;
    logic              ag_clear;
    logic              last_pix;
    logic              pipe_empty;
    logic              tap;

    raster_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (ag_clear),
        .advance (rd_en),
        .addr    (MEM_ADDR_O),
        .last    (last_pix)
    );

    assign pipe_empty = (vld_sr == '0);
    assign tap        = vld_sr[RD_LAT-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        ag_clear  = 1'b0;
        case (state)
            IDLE: begin
                ag_clear = 1'b1;
                if (START_I) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A stalled last read keeps us here until it actually goes out.
                if (!STALL_I) begin
                    rd_en = 1'b1;
                    if (last_pix) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_nxt = WAIT_CORE;
                end
            end
            WAIT_CORE: begin
                if (CORE_DONE_I) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign MEM_RD_EN_O = rd_en;
    assign BUSY_O      = (state == ISSUE) || (state == DRAIN) || (state == WAIT_CORE);
    assign CORE_RUN_O  = BUSY_O;
    assign DONE_O      = (state == DONE);

    // One valid bit per read in flight; the oldest bit lines up with MEM_DATA_I.
    generate
        if (RD_LAT == 1) begin : g_vld_lat1
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= rd_en;
                end
            end
        end else begin : g_vld_latn
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= {vld_sr[RD_LAT-2:0], rd_en};
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA_O    <= '0;
            DATA_EN_O <= 1'b0;
        end else begin
            DATA_EN_O <= tap;
            if (tap) begin
                DATA_O <= MEM_DATA_I;
            end
        end
    end

endmodule

// File: tb/tb_image_stream_reader.sv
// Drives two readers (read latency 1 and 3) with shared stimulus and checks both against
// a cycle-level model built from the frame rules: issue order, strobe timing, data, busy/done.
module tb_image_stream_reader;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int AW   = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start     = 1'b0;
    logic stall     = 1'b0;
    logic core_done = 1'b0;

    logic          rd1, en1, run1, busy1, done1;
    logic          rd3, en3, run3, busy3, done3;
    logic [AW-1:0] addr1, addr3;
    logic [7:0]    dat1, dat3;
    logic [7:0]    mdat1;
    logic [7:0]    p3 [3];

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int exp_frames = 0;

    logic [7:0] mem [2][16];

    // Reference model state, index 0 = latency 1, index 1 = latency 3.
    bit         m_busy [2];
    bit         m_done_now [2];
    int         m_issued [2];
    int         m_deliv [2];
    int         m_seen [2];
    int         m_last_strobe [2];
    int         obs_dones [2];
    int         m_head [2];
    int         m_tail [2];
    int         m_due [2][64];
    logic [7:0] m_val [2][64];
    logic [7:0] m_last_val [2];

    image_stream_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START_I(start), .STALL_I(stall), .CORE_DONE_I(core_done),
        .MEM_RD_EN_O(rd1), .MEM_ADDR_O(addr1), .MEM_DATA_I(mdat1),
        .DATA_O(dat1), .DATA_EN_O(en1), .CORE_RUN_O(run1), .BUSY_O(busy1), .DONE_O(done1)
    );

    image_stream_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .START_I(start), .STALL_I(stall), .CORE_DONE_I(core_done),
        .MEM_RD_EN_O(rd3), .MEM_ADDR_O(addr3), .MEM_DATA_I(p3[2]),
        .DATA_O(dat3), .DATA_EN_O(en3), .CORE_RUN_O(run3), .BUSY_O(busy3), .DONE_O(done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mdat1 <= mem[0][addr1];
        p3[0] <= mem[1][addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    function automatic string tg(input string s, input int lat);
        return $sformatf("%s_L%0d", s, lat);
    endfunction

    task automatic model_step(input int k, input int lat, input logic rd, input logic [AW-1:0] ad,
                              input logic en, input logic [7:0] dat, input logic run,
                              input logic busy, input logic dn);
        bit exp_rd;
        bit exp_en;
        bit go_done;
        if (!rst_n) begin
            check(tg("rst_rd_en", lat), int'(rd), 0);
            check(tg("rst_addr", lat), int'(ad), 0);
            check(tg("rst_data_en", lat), int'(en), 0);
            check(tg("rst_data", lat), int'(dat), 0);
            check(tg("rst_core_run", lat), int'(run), 0);
            check(tg("rst_busy", lat), int'(busy), 0);
            check(tg("rst_done", lat), int'(dn), 0);
            m_busy[k]        = 1'b0;
            m_done_now[k]    = 1'b0;
            m_issued[k]      = 0;
            m_deliv[k]       = 0;
            m_seen[k]        = 0;
            m_head[k]        = 0;
            m_tail[k]        = 0;
            m_last_val[k]    = 8'd0;
            m_last_strobe[k] = 0;
            return;
        end
        check(tg("busy", lat), int'(busy), int'(m_busy[k]));
        check(tg("core_run", lat), int'(run), int'(m_busy[k]));
        check(tg("done", lat), int'(dn), int'(m_done_now[k]));
        if (dn) obs_dones[k]++;

        exp_rd = m_busy[k] && (m_issued[k] < NPIX) && !stall;
        check(tg("rd_en", lat), int'(rd), int'(exp_rd));
        if (rd && exp_rd) begin
            check(tg("addr", lat), int'(ad), m_issued[k]);
            m_due[k][m_tail[k] % 64] = cyc + lat + 1;
            m_val[k][m_tail[k] % 64] = mem[k][m_issued[k]];
            m_tail[k]++;
            m_issued[k]++;
        end

        exp_en = (m_head[k] != m_tail[k]) && (m_due[k][m_head[k] % 64] == cyc);
        check(tg("data_en", lat), int'(en), int'(exp_en));
        if (en) m_seen[k]++;
        if (exp_en) begin
            m_last_val[k]    = m_val[k][m_head[k] % 64];
            m_head[k]++;
            m_deliv[k]++;
            m_last_strobe[k] = cyc;
        end
        check(tg("data", lat), int'(dat), int'(m_last_val[k]));

        // Core done counts only once every pixel is out and the reader is waiting for it.
        go_done = m_busy[k] && (m_deliv[k] == NPIX) && (cyc > m_last_strobe[k]) && core_done;
        if (m_done_now[k]) begin
            m_done_now[k] = 1'b0;
        end else if (go_done) begin
            m_done_now[k] = 1'b1;
            m_busy[k]     = 1'b0;
        end else if (!m_busy[k] && start) begin
            m_busy[k]   = 1'b1;
            m_issued[k] = 0;
            m_deliv[k]  = 0;
            m_seen[k]   = 0;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 1, rd1, addr1, en1, dat1, run1, busy1, done1);
        model_step(1, 3, rd3, addr3, en3, dat3, run3, busy3, done3);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                mem[k][i] = 8'($urandom);
    endtask

    task automatic finish_frame();
        int t;
        t = 0;
        while (!(m_busy[0] && m_busy[1] && m_deliv[0] == NPIX && m_deliv[1] == NPIX) && t < 300) begin
            tick(1);
            t++;
        end
        check("strobes_L1", m_seen[0], NPIX);
        check("strobes_L3", m_seen[1], NPIX);
        tick(3);
        core_done = 1'b1;
        exp_frames++;
        tick(1);
        core_done = 1'b0;
        t = 0;
        while ((obs_dones[0] < exp_frames || obs_dones[1] < exp_frames) && t < 20) begin
            tick(1);
            t++;
        end
        check("done_count_L1", obs_dones[0], exp_frames);
        check("done_count_L3", obs_dones[1], exp_frames);
    endtask

    initial begin
        int t;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                mem[k][i] = 8'(i + 16);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Nominal frame with a premature core done and a start retrigger mid-frame.
        start_frame();
        tick(2);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        tick(1);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        finish_frame();
        tick(2);

        // Stall on ISSUE cycles 3..5.
        randomize_mem();
        start_frame();
        tick(2);
        stall = 1'b1;
        tick(3);
        stall = 1'b0;
        finish_frame();
        tick(2);

        // Stall collides with the final read.
        randomize_mem();
        start_frame();
        t = 0;
        while (m_issued[0] < NPIX - 1 && t < 50) begin
            tick(1);
            t++;
        end
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        finish_frame();
        tick(1);

        // Random stall and core-done noise during issue.
        for (int f = 0; f < 4; f++) begin
            randomize_mem();
            start_frame();
            t = 0;
            while (m_issued[0] < NPIX && t < 200) begin
                stall     = ($urandom_range(0, 2) == 0);
                core_done = ($urandom_range(0, 5) == 0);
                tick(1);
                t++;
            end
            stall     = 1'b0;
            core_done = 1'b0;
            finish_frame();
            tick($urandom_range(1, 3));
        end

        // Reset while address 6 is being read.
        randomize_mem();
        start_frame();
        t = 0;
        while (!(rd1 && addr1 == AW'(6)) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reached_addr6", int'(addr1), 6);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd_en", int'(rd1), 0);
        check("async_rst_busy", int'(busy1), 0);
        check("async_rst_core_run", int'(run3), 0);
        check("async_rst_addr", int'(addr3), 0);
        tick(3);
        rst_n = 1'b1;
        tick(4);
        start_frame();
        finish_frame();
        tick(2);

        // Back-to-back frames with start held high.
        randomize_mem();
        start = 1'b1;
        finish_frame();
        finish_frame();
        start = 1'b0;
        tick(6);
        check("idle_after_b2b_L1", int'(busy1), 0);
        check("idle_after_b2b_L3", int'(busy3), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
